// File: rtl/dfu_boot_helper.sv
// Button conditioner and warm-boot/reset request generator for the iCE40 SB_WARMBOOT primitive.
// Pad->btn_val 6 clocks, boot_now->wb_req 1 clock, wb_boot trails wb_req by 1 clock; no backpressure.
module dfu_boot_helper #(
   parameter int TIMER_WIDTH = 24,
   parameter int BTN_MODE    = 3,
   parameter int DFU_MODE    = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       boot_now,
   input  logic [1:0] boot_sel,
   input  logic       btn_pad,
   output logic       btn_val,
   output logic       rst_req,
   output logic       wb_req,
   output logic [1:0] wb_sel,
   output logic       wb_boot
);

   localparam logic [TIMER_WIDTH-1:0] LONG_PRE = {1'b0, {(TIMER_WIDTH-1){1'b1}}};
   localparam logic [TIMER_WIDTH-1:0] ONE      = TIMER_WIDTH'(1);

   logic                   btn_pressed;
   logic                   btn_meta;
   logic                   btn_sync;
   logic [1:0]             flt_cnt;
   logic [TIMER_WIDTH-1:0] arm_cnt;
   logic [TIMER_WIDTH-1:0] press_cnt;
   logic                   armed;
   logic                   short_rel;
   logic                   long_hit;

   // Modes 2 and 3 are both active-low; the mode-3 pull-up sits in the pad's SB_IO.
   always_comb begin
      case (BTN_MODE)
         1:       btn_pressed = btn_pad;
         2, 3:    btn_pressed = ~btn_pad;
         default: btn_pressed = 1'b0;
      endcase
   end

   // Synchronizer holds the pressed polarity, so its reset value means released.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_meta <= 1'b0;
         btn_sync <= 1'b0;
         flt_cnt  <= 2'd0;
         btn_val  <= 1'b0;
      end else begin
         btn_meta <= btn_pressed;
         btn_sync <= btn_meta;
         if (btn_sync == btn_val) begin
            flt_cnt <= 2'd0;
         end else if (flt_cnt == 2'd3) begin
            btn_val <= btn_sync;
            flt_cnt <= 2'd0;
         end else begin
            flt_cnt <= flt_cnt + 2'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         arm_cnt   <= '0;
         armed     <= 1'b0;
         press_cnt <= '0;
      end else begin
         if (btn_val) begin
            arm_cnt <= '0;
         end else if (!armed) begin
            arm_cnt <= arm_cnt + ONE;
         end
         armed <= armed | arm_cnt[TIMER_WIDTH-1];

         if (!btn_val) begin
            press_cnt <= '0;
         end else if (!press_cnt[TIMER_WIDTH-1]) begin
            press_cnt <= press_cnt + ONE;
         end
      end
   end

   // Both events are single-cycle: the counter clears or saturates on the following edge.
   assign short_rel = !btn_val && (press_cnt != '0) && !press_cnt[TIMER_WIDTH-1];
   assign long_hit  = btn_val && (press_cnt == LONG_PRE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_req <= 1'b0;
         wb_req  <= 1'b0;
         wb_sel  <= 2'b00;
         wb_boot <= 1'b0;
      end else begin
         rst_req <= 1'b0;
         wb_boot <= wb_req;
         if (!wb_req) begin
            if (boot_now) begin
               wb_req <= 1'b1;
               wb_sel <= boot_sel;
            end else if (armed) begin
               if (short_rel) begin
                  if (DFU_MODE != 0) begin
                     wb_req <= 1'b1;
                     wb_sel <= 2'b10;
                  end else begin
                     rst_req <= 1'b1;
                  end
               end
               if (long_hit) begin
                  if (DFU_MODE != 0) begin
                     rst_req <= 1'b1;
                  end else begin
                     wb_req <= 1'b1;
                     wb_sel <= 2'b01;
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_dfu_boot_helper.sv
// Bench for dfu_boot_helper: one DFU_MODE=1 and one DFU_MODE=0 instance share all inputs.
// Table vectors, hand sequences and a random phase, all checked against a run-length reference model.
module tb_dfu_boot_helper;

   localparam int TW  = 8;
   localparam int THR = 1 << (TW - 1);

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       boot_now = 1'b0;
   logic [1:0] boot_sel = 2'b00;
   logic       btn_pad = 1'b1;

   logic       bv1, rr1, wr1, wbb1;
   logic [1:0] ws1;
   logic       bv0, rr0, wr0, wbb0;
   logic [1:0] ws0;

   int total = 0;
   int bad   = 0;
   int n_rst1 = 0;
   int n_rst0 = 0;

   always #5 clk = ~clk;

   dfu_boot_helper #(.TIMER_WIDTH(TW), .BTN_MODE(2), .DFU_MODE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .boot_now(boot_now), .boot_sel(boot_sel), .btn_pad(btn_pad),
      .btn_val(bv1), .rst_req(rr1), .wb_req(wr1), .wb_sel(ws1), .wb_boot(wbb1)
   );

   dfu_boot_helper #(.TIMER_WIDTH(TW), .BTN_MODE(2), .DFU_MODE(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .boot_now(boot_now), .boot_sel(boot_sel), .btn_pad(btn_pad),
      .btn_val(bv0), .rst_req(rr0), .wb_req(wr0), .wb_sel(ws0), .wb_boot(wbb0)
   );

   // Reference model: sample window for the filter, run lengths for arming and press duration.
   bit       m_val;
   bit [3:0] m_win;
   bit       m_d1, m_d2;
   int       m_zero, m_hold;
   bit       m_armed;
   bit       m_wb[2];
   bit [1:0] m_sel[2];
   bit       m_rst[2];
   bit       m_boot[2];

   task automatic model_reset();
      m_val = 1'b0; m_win = 4'h0; m_d1 = 1'b0; m_d2 = 1'b0;
      m_zero = 0; m_hold = 0; m_armed = 1'b0;
      for (int d = 0; d < 2; d++) begin
         m_wb[d] = 1'b0; m_sel[d] = 2'b00; m_rst[d] = 1'b0; m_boot[d] = 1'b0;
      end
   endtask

   task automatic model_step();
      bit s, long_ev, short_ev;
      s        = ~btn_pad;
      long_ev  = m_val && (m_hold == THR - 1);
      short_ev = !m_val && (m_hold > 0) && (m_hold < THR);
      for (int d = 0; d < 2; d++) begin
         m_boot[d] = m_wb[d];
         m_rst[d]  = 1'b0;
         if (!m_wb[d]) begin
            if (boot_now) begin
               m_wb[d] = 1'b1; m_sel[d] = boot_sel;
            end else if (m_armed) begin
               if (short_ev) begin
                  if (d == 1) begin m_wb[d] = 1'b1; m_sel[d] = 2'b10; end
                  else m_rst[d] = 1'b1;
               end
               if (long_ev) begin
                  if (d == 1) m_rst[d] = 1'b1;
                  else begin m_wb[d] = 1'b1; m_sel[d] = 2'b01; end
               end
            end
         end
      end
      if (m_zero >= THR) m_armed = 1'b1;
      m_zero = m_val ? 0 : m_zero + 1;
      m_hold = m_val ? m_hold + 1 : 0;
      m_win  = {m_win[2:0], m_d2};
      m_d2   = m_d1;
      m_d1   = s;
      if (m_win == 4'hF) m_val = 1'b1;
      else if (m_win == 4'h0) m_val = 1'b0;
   endtask

   function automatic logic [5:0] act_vec(input int d);
      return (d == 1) ? {bv1, rr1, wr1, ws1, wbb1} : {bv0, rr0, wr0, ws0, wbb0};
   endfunction

   function automatic logic [5:0] exp_vec(input int d);
      return {m_val, m_rst[d], m_wb[d], m_sel[d], m_boot[d]};
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Inputs change only at the falling edge; the model advances at the rising edge.
   task automatic tick();
      @(posedge clk);
      if (rst_n) model_step();
      @(negedge clk);
      n_rst1 += int'(rr1);
      n_rst0 += int'(rr0);
      chk("cyc_dfu1", int'(act_vec(1)), int'(exp_vec(1)));
      chk("cyc_dfu0", int'(act_vec(0)), int'(exp_vec(0)));
   endtask

   task automatic do_reset(input logic pad);
      btn_pad  = pad;
      boot_now = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_dfu1", int'(act_vec(1)), 0);
      chk("arst_dfu0", int'(act_vec(0)), 0);
      model_reset();
      repeat (3) tick();
      rst_n = 1'b1;
   endtask

   typedef struct {
      bit       rst_first;
      bit       pad;
      int       cyc;
      int       rst1;
      bit       wb1;
      bit [1:0] sel1;
      int       rst0;
      bit       wb0;
      bit [1:0] sel0;
   } vec_t;

   vec_t vt[10];

   initial begin
      int r1, r0, t_rise, t_pulse, seen, len;

      vt[0] = '{1'b1, 1'b0,  50, 0, 1'b0, 2'b00, 0, 1'b0, 2'b00};
      vt[1] = '{1'b0, 1'b1, 200, 0, 1'b0, 2'b00, 0, 1'b0, 2'b00};
      vt[2] = '{1'b0, 1'b0,  40, 0, 1'b0, 2'b00, 0, 1'b0, 2'b00};
      vt[3] = '{1'b0, 1'b1,  20, 0, 1'b1, 2'b10, 1, 1'b0, 2'b00};
      vt[4] = '{1'b0, 1'b1, 150, 0, 1'b1, 2'b10, 0, 1'b0, 2'b00};
      vt[5] = '{1'b0, 1'b0, 300, 0, 1'b1, 2'b10, 0, 1'b1, 2'b01};
      vt[6] = '{1'b0, 1'b1,  20, 0, 1'b1, 2'b10, 0, 1'b1, 2'b01};
      vt[7] = '{1'b1, 1'b1, 200, 0, 1'b0, 2'b00, 0, 1'b0, 2'b00};
      vt[8] = '{1'b0, 1'b0, 300, 1, 1'b0, 2'b00, 0, 1'b1, 2'b01};
      vt[9] = '{1'b0, 1'b1,  20, 0, 1'b0, 2'b00, 0, 1'b1, 2'b01};

      // Software request: registered, sticky, BOOT one clock behind.
      do_reset(1'b1);
      boot_now = 1'b1; boot_sel = 2'b11;
      tick();
      chk("sw_wb_req", int'(wr1), 1);
      chk("sw_wb_sel", int'(ws1), 3);
      chk("sw_boot_early", int'(wbb1), 0);
      boot_now = 1'b0;
      tick();
      chk("sw_boot_late", int'(wbb1), 1);
      boot_now = 1'b1; boot_sel = 2'b00;
      tick();
      chk("sw_sel_frozen", int'(ws1), 3);
      chk("sw_sel_frozen_dfu0", int'(ws0), 3);
      boot_now = 1'b0;

      for (int i = 0; i < 10; i++) begin
         if (vt[i].rst_first) do_reset(vt[i].pad);
         r1 = n_rst1; r0 = n_rst0;
         btn_pad = vt[i].pad;
         repeat (vt[i].cyc) tick();
         chk($sformatf("vec%0d_rst1", i), n_rst1 - r1, vt[i].rst1);
         chk($sformatf("vec%0d_wb1", i), int'(wr1), int'(vt[i].wb1));
         chk($sformatf("vec%0d_sel1", i), int'(ws1), int'(vt[i].sel1));
         chk($sformatf("vec%0d_rst0", i), n_rst0 - r0, vt[i].rst0);
         chk($sformatf("vec%0d_wb0", i), int'(wr0), int'(vt[i].wb0));
         chk($sformatf("vec%0d_sel0", i), int'(ws0), int'(vt[i].sel0));
      end

      // Long press in DFU_MODE=1: exactly one pulse, THR clocks after btn_val rises.
      r1 = n_rst1; t_rise = -1; t_pulse = -1;
      btn_pad = 1'b0;
      for (int c = 0; c < 200 && t_pulse < 0; c++) begin
         tick();
         if (t_rise < 0 && bv1) t_rise = c;
         if (rr1) t_pulse = c;
      end
      chk("long_rise_seen", int'(t_rise >= 0), 1);
      chk("long_pulse_delay", t_pulse - t_rise, THR);
      repeat (100) tick();
      btn_pad = 1'b1;
      repeat (20) tick();
      chk("long_single_pulse", n_rst1 - r1, 1);
      chk("long_release_no_wb", int'(wr1), 0);

      // Pad glitches of 1..3 clocks never reach btn_val.
      r1 = n_rst1;
      for (int w = 1; w <= 3; w++) begin
         seen = 0;
         btn_pad = 1'b0;
         repeat (w) begin tick(); seen += int'(bv1); end
         btn_pad = 1'b1;
         repeat (12) begin tick(); seen += int'(bv1); end
         chk($sformatf("glitch_w%0d", w), seen, 0);
      end
      chk("glitch_no_rst", n_rst1 - r1, 0);
      chk("glitch_no_wb", int'(wr1), 0);

      // Reset mid-press, then a release right after reset must not act.
      btn_pad = 1'b0;
      repeat (20) tick();
      chk("press_before_rst", int'(bv1), 1);
      do_reset(1'b0);
      repeat (20) tick();
      r1 = n_rst1; r0 = n_rst0;
      btn_pad = 1'b1;
      repeat (60) tick();
      chk("post_rst_release_rst1", n_rst1 - r1, 0);
      chk("post_rst_release_wb1", int'(wr1), 0);
      chk("post_rst_release_rst0", n_rst0 - r0, 0);

      // Random press trains with rare software requests and resets.
      do_reset(1'b1);
      for (int s = 0; s < 60; s++) begin
         btn_pad = ~btn_pad;
         case ($urandom_range(0, 2))
            0:       len = $urandom_range(1, 6);
            1:       len = $urandom_range(8, 100);
            default: len = $urandom_range(120, 260);
         endcase
         for (int c = 0; c < len; c++) begin
            boot_now = ($urandom_range(0, 599) == 0);
            boot_sel = 2'($urandom_range(0, 3));
            tick();
         end
         boot_now = 1'b0;
         if ($urandom_range(0, 11) == 0) do_reset(btn_pad);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dfu_boot_helper.md
# dfu_boot_helper

Warm-boot and button helper for the iCE40 SoC. It conditions the user push-button, classifies presses as short or long, and turns them, or a software boot request, into a warm-boot into a selected bitstream image or a reset request. It sits beside the CPU's boot-control register and drives the `SB_WARMBOOT` primitive.

## Interface
Parameters:
- `TIMER_WIDTH`, default 24: width of the press/arming timer. Long-press and arming threshold is `2^(TIMER_WIDTH-1)` clocks.
- `BTN_MODE`, default 3: button input mode.
  - 0: button ignored.
  - 1: raw active-high.
  - 2: raw active-low.
  - 3: active-low with internal pull-up (`SB_IO` input, `PULLUP=1`).
- `DFU_MODE`, default 1: 1 = block is in the bootloader, 0 = block is in the user application.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `boot_now` in 1: software warm-boot request; level-sensitive.
- `boot_sel` in 2: image selected for the software request.
- `btn_pad` in 1: button pad.
- `btn_val` out 1: debounced button state, 1 = pressed.
- `rst_req` out 1: one-clock reset-request pulse.
- `wb_req` out 1: warm-boot request, sticky; also drives `SB_WARMBOOT.BOOT` one cycle delayed.
- `wb_sel` out 2: warm-boot image; drives `SB_WARMBOOT.S1/S0`.

## Operation
Button conditioning:
- Pad goes through a 2-FF synchronizer.
- Inversion is applied per `BTN_MODE`, so that 1 = pressed.
- A glitch filter follows. `btn_val` changes only after 4 consecutive identical synchronized samples.
- `BTN_MODE=0`: `btn_val` is forced to 0.

Arming:
- After reset the button is disarmed.
- It arms once `btn_val` has been 0 for `2^(TIMER_WIDTH-1)` consecutive clocks.
- It stays armed until reset.
- A button held through power-up therefore never triggers an action.

Press timer:
- `TIMER_WIDTH`-bit counter. Clears when `btn_val`=0, increments while `btn_val`=1.
- It saturates once the MSB is set. MSB set = long press.

Actions are taken only when armed and no warm-boot is latched:
- `DFU_MODE=1`:
  - Release before the MSB is set (short press): warm-boot with `wb_sel`=2'b10 (user image).
  - MSB reached while held (long press): one `rst_req` pulse, emitted once per press.
- `DFU_MODE=0`:
  - Short press release: one `rst_req` pulse.
  - Long press, on the cycle the MSB sets: warm-boot with `wb_sel`=2'b01 (bootloader image).

Software request:
- `boot_now`=1 latches a warm-boot with `wb_sel`=`boot_sel`.
- It does not depend on arming.
- It has priority over a button action in the same cycle.

Warm-boot latch:
- Once set, `wb_req`=1 and `wb_sel` are frozen until reset.
- All later `boot_now`/button events are ignored.
- `SB_WARMBOOT.BOOT` is asserted one cycle after `wb_req`, so S1/S0 are stable first.

## Timing
- Reset values: `btn_val`=0, `rst_req`=0, `wb_req`=0, `wb_sel`=2'b00. Timer is 0 and the helper is disarmed.
- `boot_now` to `wb_req`/`wb_sel` is 1 clock (registered).
- Pad edge to `btn_val` is 2 synchronizer clocks plus 4 filter clocks, i.e. 6 clocks.
- Short-release action happens in the cycle after `btn_val` falls. `rst_req` is high for exactly 1 clock.
- A long press is detected `2^(TIMER_WIDTH-1)` clocks after `btn_val` rises. In `DFU_MODE=1` the `rst_req` pulse fires on that cycle. The later release is not a short press.
- A glitch shorter than 4 samples produces no `btn_val` change.
- Reset mid-press: the helper disarms, so a new full release period is needed.

## Test plan
Use `TIMER_WIDTH=8`, so the threshold is 128 clocks, and `BTN_MODE=2`.
1. Reset, `boot_now`=1 with `boot_sel`=2'b11 -> next clock `wb_req`=1, `wb_sel`=2'b11, `BOOT` asserted one clock later. A later `boot_now` with `boot_sel`=2'b00 leaves `wb_sel`=2'b11.
2. `btn_pad` held low (pressed) from reset, then released after 50 clocks -> no `rst_req`, no `wb_req`.
3. `DFU_MODE=1`: release for 200 clocks, press for 40 clocks, release -> `wb_req`=1, `wb_sel`=2'b10. `rst_req` stays 0.
4. `DFU_MODE=1`: armed, press for 300 clocks -> a single `rst_req` pulse 128 clocks after `btn_val` rises. Release gives no `wb_req`.
5. `DFU_MODE=0`: armed, press for 40 clocks -> one `rst_req` pulse after release. Then press for 200 clocks -> `wb_req`=1, `wb_sel`=2'b01.
6. Armed, pad pulses of 1-3 clocks -> `btn_val` stays 0, no action. Async `rst_n` low mid-press -> all outputs return to reset values immediately.
